// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one ROM read port between fetch (I) and load (D).
// Returns registered-valid responses with range check and a conflict counter.
module rom_port_arbiter #(
  parameter int ROM_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [29:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  output logic             i_err,
  input  logic             d_req,
  input  logic [29:0]      d_addr,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic [29:0]      rom_addr,
  input  logic [31:0]      rom_inst,
  output logic [CNT_W-1:0] conflict_cnt,
  input  logic             clr_cnt
);

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [29:0] LIMIT = 30'(ROM_WORDS);

  port_t       last_gnt;
  port_t       sel_q;
  logic [29:0] held_addr;
  logic        valid_q;
  logic        err_q;
  logic        any_gnt;
  logic        both;

  assign both    = i_req && d_req;
  assign any_gnt = i_gnt || d_gnt;

  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    rom_addr = held_addr;
    if (rst_n) begin
      i_gnt = i_req && (!d_req || last_gnt == PORT_D);
      d_gnt = d_req && !i_gnt;
    end
    unique case (1'b1)
      i_gnt:   rom_addr = i_addr;
      d_gnt:   rom_addr = d_addr;
      default: rom_addr = held_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt  <= PORT_D;
      sel_q     <= PORT_I;
      held_addr <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= any_gnt;
      if (any_gnt) begin
        last_gnt  <= i_gnt ? PORT_I : PORT_D;
        sel_q     <= i_gnt ? PORT_I : PORT_D;
        held_addr <= rom_addr;
        err_q     <= rom_addr >= LIMIT;
      end
    end
  end

  // rst_n gating kills a response that was pending when reset arrived
  always_comb begin
    i_rvalid = rst_n && valid_q && sel_q == PORT_I;
    d_rvalid = rst_n && valid_q && sel_q == PORT_D;
    i_err    = i_rvalid && err_q;
    d_err    = d_rvalid && err_q;
    i_rdata  = (i_rvalid && !err_q) ? rom_inst : 32'h0;
    d_rdata  = (d_rvalid && !err_q) ? rom_inst : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (clr_cnt) begin
      conflict_cnt <= '0;
    end else if (both && !(&conflict_cnt)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a registered ROM model.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_rom_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic [29:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [29:0] rom_addr;
  logic [31:0] rom_inst;
  logic [3:0]  conflict_cnt;
  logic        clr_cnt;

  int n_run;
  int n_fail;

  rom_port_arbiter #(
    .ROM_WORDS(1024),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_gnt(i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata(i_rdata),
    .i_err(i_err),
    .d_req(d_req),
    .d_addr(d_addr),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .d_err(d_err),
    .rom_addr(rom_addr),
    .rom_inst(rom_inst),
    .conflict_cnt(conflict_cnt),
    .clr_cnt(clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    case (a)
      30'h1:   return 32'h0c000343;
      30'h2:   return 32'h37bd0d00;
      30'h3:   return 32'h8fbf0014;
      30'h4:   return 32'hafa00010;
      default: return {16'hdead, a[15:0]};
    endcase
  endfunction

  always @(posedge clk) rom_inst <= rom_word(rom_addr);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    i_req    = 1'b0;
    d_req    = 1'b0;
    i_addr   = '0;
    d_addr   = '0;
    clr_cnt  = 1'b0;
    rom_inst = '0;

    // reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_i_gnt", 32'(i_gnt), 32'h0);
    check("idle_d_gnt", 32'(d_gnt), 32'h0);
    check("idle_i_rvalid", 32'(i_rvalid), 32'h0);
    check("idle_d_rvalid", 32'(d_rvalid), 32'h0);
    check("idle_rom_addr", 32'(rom_addr), 32'h0);
    check("idle_cnt", 32'(conflict_cnt), 32'h0);
    drive();
    @(negedge clk);
    check("idle_hold_addr", 32'(rom_addr), 32'h0);

    // single I access
    drive();
    i_req  = 1'b1;
    i_addr = 30'h1;
    @(negedge clk);
    check("single_i_gnt", 32'(i_gnt), 32'h1);
    check("single_d_gnt", 32'(d_gnt), 32'h0);
    check("single_rom_addr", 32'(rom_addr), 32'h1);
    drive();
    i_req = 1'b0;
    @(negedge clk);
    check("single_i_rvalid", 32'(i_rvalid), 32'h1);
    check("single_i_rdata", i_rdata, 32'h0c000343);
    check("single_i_err", 32'(i_err), 32'h0);
    check("single_d_rvalid", 32'(d_rvalid), 32'h0);
    check("single_held_addr", 32'(rom_addr), 32'h1);

    // D out of range, then last valid word back-to-back
    drive();
    d_req  = 1'b1;
    d_addr = 30'h400;
    @(negedge clk);
    check("oor_d_gnt", 32'(d_gnt), 32'h1);
    drive();
    d_addr = 30'h3ff;
    @(negedge clk);
    check("oor_d_rvalid", 32'(d_rvalid), 32'h1);
    check("oor_d_err", 32'(d_err), 32'h1);
    check("oor_d_rdata", d_rdata, 32'h0);
    check("oor_i_rvalid", 32'(i_rvalid), 32'h0);
    drive();
    d_req = 1'b0;
    @(negedge clk);
    check("edge_d_rvalid", 32'(d_rvalid), 32'h1);
    check("edge_d_err", 32'(d_err), 32'h0);
    check("edge_d_rdata", d_rdata, 32'hdead03ff);

    // contention: I,D,I,D with responses one cycle later
    for (int k = 0; k < 4; k++) begin
      drive();
      i_req  = 1'b1;
      i_addr = 30'h2;
      d_req  = 1'b1;
      d_addr = 30'h4;
      @(negedge clk);
      check("cont_i_gnt", 32'(i_gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
      check("cont_d_gnt", 32'(d_gnt), (k % 2 == 0) ? 32'h0 : 32'h1);
      check("cont_rom_addr", 32'(rom_addr),
            (k % 2 == 0) ? 32'h2 : 32'h4);
      if (k > 0) begin
        if (k % 2 == 1) check("cont_i_rdata", i_rdata, 32'h37bd0d00);
        else check("cont_d_rdata", d_rdata, 32'hafa00010);
      end
    end
    drive();
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check("cont_last_d_rvalid", 32'(d_rvalid), 32'h1);
    check("cont_last_d_rdata", d_rdata, 32'hafa00010);
    check("cont_cnt", 32'(conflict_cnt), 32'h4);

    // saturation then clear during a conflict
    drive();
    i_req = 1'b1;
    d_req = 1'b1;
    repeat (19) drive();
    @(negedge clk);
    check("sat_cnt_before", 32'(conflict_cnt), 32'hf);
    drive();
    @(negedge clk);
    check("sat_cnt", 32'(conflict_cnt), 32'hf);
    clr_cnt = 1'b1;
    drive();
    clr_cnt = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    @(negedge clk);
    check("clr_cnt", 32'(conflict_cnt), 32'h0);

    // reset mid-access
    drive();
    i_req  = 1'b1;
    i_addr = 30'h3;
    @(negedge clk);
    check("rst_i_gnt", 32'(i_gnt), 32'h1);
    drive();
    rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    check("rst_i_rvalid_0", 32'(i_rvalid), 32'h0);
    check("rst_i_gnt_low", 32'(i_gnt), 32'h0);
    drive();
    @(negedge clk);
    check("rst_i_rvalid_1", 32'(i_rvalid), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    drive();
    rst_n  = 1'b1;
    i_req  = 1'b1;
    d_req  = 1'b1;
    i_addr = 30'h2;
    d_addr = 30'h4;
    @(negedge clk);
    check("rst_i_rvalid_2", 32'(i_rvalid), 32'h0);
    check("rst_tie_i_gnt", 32'(i_gnt), 32'h1);
    check("rst_tie_d_gnt", 32'(d_gnt), 32'h0);
    drive();
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check("rst_tie_i_rdata", i_rdata, 32'h37bd0d00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
